mem_port_arbiter: RTL and testbench

MEM_PORT_ARBITER -- requirements
Module: mem_port_arbiter

---
 rtl/mem_port_arbiter.sv | 165 ++++++++++++++++
 tb/tb_mem_port_arbiter.sv | 242 ++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares one single-port memory between an instruction
// fetch requester and a load/store requester. Writes finish in their grant
// cycle. A read keeps the port busy until its data returns LAT cycles
// later, and a new grant may be issued in that same return cycle so that
// reads can be pipelined back to back. Round-robin on ties.
module mem_port_arbiter #(
  parameter int W_CPU = 32,
  parameter int LAT   = 1
) (
  input  logic             clk,
  input  logic             rst,
  // fetch requester
  input  logic             if_req,
  input  logic [W_CPU-1:0] if_addr,
  output logic             if_gnt,
  output logic             if_rvalid,
  output logic [W_CPU-1:0] if_rdata,
  // data requester
  input  logic             d_req,
  input  logic             d_we,
  input  logic [W_CPU-1:0] d_addr,
  input  logic [W_CPU-1:0] d_wdata,
  output logic             d_gnt,
  output logic             d_rvalid,
  output logic [W_CPU-1:0] d_rdata,
  // memory port
  output logic             m_en,
  output logic             m_we,
  output logic [W_CPU-1:0] m_addr,
  output logic [W_CPU-1:0] m_wdata,
  input  logic [W_CPU-1:0] m_rdata,
  output logic             stall
);

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    WAIT = 1'b1
  } state_t;

  // Owner / last-grant encoding: 0 = fetch, 1 = data.
  localparam logic OWN_FETCH = 1'b0;
  localparam logic OWN_DATA  = 1'b1;

  // The counter is 3 bits wide; LAT is limited to 1..4 so it never wraps.
  localparam logic [2:0] LAT_C = 3'(LAT);

  state_t     state_r;
  logic [2:0] cnt_r;
  logic       owner_r;
  logic       last_gnt_r;

  logic       ret_s;
  logic       can_grant_s;
  logic       pick_d_s;
  logic       grant_if_s;
  logic       grant_d_s;
  logic       grant_rd_s;

  // Decide whether the port may grant this cycle, and to whom.
  always_comb begin
    ret_s       = 1'b0;
    can_grant_s = 1'b0;
    pick_d_s    = 1'b0;
    grant_if_s  = 1'b0;
    grant_d_s   = 1'b0;
    grant_rd_s  = 1'b0;

    if ((state_r == WAIT) && (cnt_r == LAT_C)) begin
      ret_s = 1'b1;
    end else begin
      ret_s = 1'b0;
    end

    // Reset overrides any grant, including the one a return cycle would make.
    if (!rst && ((state_r == IDLE) || ret_s)) begin
      can_grant_s = 1'b1;
    end else begin
      can_grant_s = 1'b0;
    end

    // Data wins when alone, or on a tie when fetch was granted last.
    if (d_req && (!if_req || (last_gnt_r == OWN_FETCH))) begin
      pick_d_s = 1'b1;
    end else begin
      pick_d_s = 1'b0;
    end

    grant_d_s  = can_grant_s & d_req & pick_d_s;
    grant_if_s = can_grant_s & if_req & ~pick_d_s;
    grant_rd_s = grant_if_s | (grant_d_s & ~d_we);
  end

  // Port state: idle/wait, latency counter, read owner and round-robin pointer.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r    <= IDLE;
      cnt_r      <= 3'd0;
      owner_r    <= OWN_FETCH;
      last_gnt_r <= OWN_FETCH;
    end else if (grant_if_s || grant_d_s) begin
      last_gnt_r <= grant_d_s ? OWN_DATA : OWN_FETCH;
      if (grant_rd_s) begin
        state_r <= WAIT;
        cnt_r   <= 3'd1;
        owner_r <= grant_d_s ? OWN_DATA : OWN_FETCH;
      end else begin
        state_r <= IDLE;
        cnt_r   <= 3'd0;
      end
    end else if (state_r == WAIT) begin
      if (ret_s) begin
        state_r <= IDLE;
        cnt_r   <= 3'd0;
      end else begin
        cnt_r   <= cnt_r + 3'd1;
      end
    end else begin
      state_r <= state_r;
      cnt_r   <= cnt_r;
    end
  end

  // Memory port, grants, read-data return and stall.
  always_comb begin
    if_gnt    = grant_if_s;
    d_gnt     = grant_d_s;
    m_en      = grant_if_s | grant_d_s;
    m_we      = grant_d_s & d_we;
    m_addr    = {W_CPU{1'b0}};
    m_wdata   = {W_CPU{1'b0}};
    if_rvalid = 1'b0;
    d_rvalid  = 1'b0;
    if_rdata  = {W_CPU{1'b0}};
    d_rdata   = {W_CPU{1'b0}};

    if (grant_d_s) begin
      m_addr  = d_addr;
      m_wdata = d_wdata;
    end else if (grant_if_s) begin
      m_addr  = if_addr;
      m_wdata = {W_CPU{1'b0}};
    end else begin
      m_addr  = {W_CPU{1'b0}};
      m_wdata = {W_CPU{1'b0}};
    end

    // A reset in the return cycle kills the outstanding read's data.
    if (ret_s && !rst) begin
      if (owner_r == OWN_DATA) begin
        d_rvalid = 1'b1;
        d_rdata  = m_rdata;
      end else begin
        if_rvalid = 1'b1;
        if_rdata  = m_rdata;
      end
    end else begin
      if_rvalid = 1'b0;
      d_rvalid  = 1'b0;
    end

    stall = (if_req & ~grant_if_s) | (d_req & ~grant_d_s) |
            ((state_r == WAIT) & ~(if_rvalid | d_rvalid));
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Testbench for mem_port_arbiter: instance 0 runs with LAT=1, instance 1
// with LAT=3. A transaction-level model (outstanding read tagged with its
// issue cycle number) predicts every output each cycle.
module tb_mem_port_arbiter;

  logic clk;
  logic        rst      [2];
  logic        if_req   [2];
  logic [31:0] if_addr  [2];
  logic        if_gnt   [2];
  logic        if_rvalid[2];
  logic [31:0] if_rdata [2];
  logic        d_req    [2];
  logic        d_we     [2];
  logic [31:0] d_addr   [2];
  logic [31:0] d_wdata  [2];
  logic        d_gnt    [2];
  logic        d_rvalid [2];
  logic [31:0] d_rdata  [2];
  logic        m_en     [2];
  logic        m_we     [2];
  logic [31:0] m_addr   [2];
  logic [31:0] m_wdata  [2];
  logic [31:0] m_rdata  [2];
  logic        stall    [2];

  int tests = 0;
  int fails = 0;
  int cyc   = 0;
  int lat   [2] = '{1, 3};

  // reference model state
  bit out_s [2];
  int issue [2];
  bit own_d [2];
  bit last_d[2];
  // model predictions for the current cycle
  bit e_ret[2], e_ifg[2], e_dg[2], e_ifv[2], e_dv[2], e_stall[2];
  logic [31:0] e_addr[2], e_wdata[2];

  mem_port_arbiter #(.W_CPU(32), .LAT(1)) u_lat1 (
    .clk(clk), .rst(rst[0]),
    .if_req(if_req[0]), .if_addr(if_addr[0]), .if_gnt(if_gnt[0]),
    .if_rvalid(if_rvalid[0]), .if_rdata(if_rdata[0]),
    .d_req(d_req[0]), .d_we(d_we[0]), .d_addr(d_addr[0]), .d_wdata(d_wdata[0]),
    .d_gnt(d_gnt[0]), .d_rvalid(d_rvalid[0]), .d_rdata(d_rdata[0]),
    .m_en(m_en[0]), .m_we(m_we[0]), .m_addr(m_addr[0]), .m_wdata(m_wdata[0]),
    .m_rdata(m_rdata[0]), .stall(stall[0])
  );

  mem_port_arbiter #(.W_CPU(32), .LAT(3)) u_lat3 (
    .clk(clk), .rst(rst[1]),
    .if_req(if_req[1]), .if_addr(if_addr[1]), .if_gnt(if_gnt[1]),
    .if_rvalid(if_rvalid[1]), .if_rdata(if_rdata[1]),
    .d_req(d_req[1]), .d_we(d_we[1]), .d_addr(d_addr[1]), .d_wdata(d_wdata[1]),
    .d_gnt(d_gnt[1]), .d_rvalid(d_rvalid[1]), .d_rdata(d_rdata[1]),
    .m_en(m_en[1]), .m_we(m_we[1]), .m_addr(m_addr[1]), .m_wdata(m_wdata[1]),
    .m_rdata(m_rdata[1]), .stall(stall[1])
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input int i, input logic [31:0] obs,
                     input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s[lat%0d] cyc %0d: observed %h expected %h",
             tag, lat[i], cyc, obs, exp);
    end
  endtask

  // Predict this cycle's outputs from the transaction-level state.
  task automatic model_eval(input int i);
    bit free, win_d;
    e_ret[i] = out_s[i] && (cyc == issue[i] + lat[i]);
    free     = !out_s[i] || e_ret[i];
    e_ifv[i] = e_ret[i] && !own_d[i] && !rst[i];
    e_dv[i]  = e_ret[i] &&  own_d[i] && !rst[i];
    if (d_req[i] && if_req[i]) win_d = !last_d[i];
    else                       win_d = d_req[i];
    e_dg[i]  = free && !rst[i] && d_req[i] && win_d;
    e_ifg[i] = free && !rst[i] && if_req[i] && !win_d;
    e_addr[i]  = e_dg[i] ? d_addr[i] : (e_ifg[i] ? if_addr[i] : 32'h0);
    e_wdata[i] = e_dg[i] ? d_wdata[i] : 32'h0;
    e_stall[i] = (if_req[i] && !e_ifg[i]) || (d_req[i] && !e_dg[i]) ||
                 (out_s[i] && !(e_ifv[i] || e_dv[i]));
  endtask

  task automatic model_update(input int i);
    if (rst[i]) begin
      out_s[i] = 1'b0; own_d[i] = 1'b0; last_d[i] = 1'b0;
    end else if (e_dg[i] || e_ifg[i]) begin
      last_d[i] = e_dg[i];
      if (e_ifg[i] || !d_we[i]) begin
        out_s[i] = 1'b1; issue[i] = cyc; own_d[i] = e_dg[i];
      end else begin
        out_s[i] = 1'b0;
      end
    end else if (e_ret[i]) begin
      out_s[i] = 1'b0;
    end
  endtask

  task automatic compare(input int i);
    chk("if_gnt",    i, {31'd0, if_gnt[i]},    {31'd0, e_ifg[i]});
    chk("d_gnt",     i, {31'd0, d_gnt[i]},     {31'd0, e_dg[i]});
    chk("if_rvalid", i, {31'd0, if_rvalid[i]}, {31'd0, e_ifv[i]});
    chk("d_rvalid",  i, {31'd0, d_rvalid[i]},  {31'd0, e_dv[i]});
    chk("if_rdata",  i, if_rdata[i], e_ifv[i] ? m_rdata[i] : 32'h0);
    chk("d_rdata",   i, d_rdata[i],  e_dv[i]  ? m_rdata[i] : 32'h0);
    chk("m_en",      i, {31'd0, m_en[i]},  {31'd0, e_dg[i] | e_ifg[i]});
    chk("m_we",      i, {31'd0, m_we[i]},  {31'd0, e_dg[i] & d_we[i]});
    chk("m_addr",    i, m_addr[i],  e_addr[i]);
    chk("m_wdata",   i, m_wdata[i], e_wdata[i]);
    chk("stall",     i, {31'd0, stall[i]}, {31'd0, e_stall[i]});
  endtask

  // One clock cycle: fresh memory data, check mid-cycle, advance model.
  task automatic step();
    for (int i = 0; i < 2; i++) m_rdata[i] = $urandom;
    #3;
    for (int i = 0; i < 2; i++) begin
      model_eval(i);
      compare(i);
    end
    @(posedge clk);
    for (int i = 0; i < 2; i++) model_update(i);
    cyc++;
    #1;
  endtask

  // Random requester behaviour that honours the hold-until-granted rule
  // except for occasional legal drops, with rare resets.
  task automatic drive_rand(input int i);
    if (e_ifg[i] || !if_req[i]) begin
      if_req[i]  = 1'($urandom_range(0, 1));
      if_addr[i] = $urandom;
    end else if ($urandom_range(0, 15) == 0) begin
      if_req[i] = 1'b0;
    end
    if (e_dg[i] || !d_req[i]) begin
      d_req[i]   = 1'($urandom_range(0, 1));
      d_we[i]    = 1'($urandom_range(0, 1));
      d_addr[i]  = $urandom;
      d_wdata[i] = $urandom;
    end else if ($urandom_range(0, 15) == 0) begin
      d_req[i] = 1'b0;
    end
    rst[i] = ($urandom_range(0, 63) == 0);
  endtask

  task automatic idle(input int i);
    if_req[i] = 1'b0; d_req[i] = 1'b0; d_we[i] = 1'b0;
    if_addr[i] = 32'h0; d_addr[i] = 32'h0; d_wdata[i] = 32'h0;
  endtask

  initial begin
    for (int i = 0; i < 2; i++) begin
      idle(i);
      rst[i] = 1'b1; m_rdata[i] = 32'h0;
      out_s[i] = 1'b0; issue[i] = 0; own_d[i] = 1'b0; last_d[i] = 1'b0;
    end
    @(posedge clk);
    #1;
    // reset cycle and the cycle after it
    step();
    rst[0] = 1'b0; rst[1] = 1'b0;
    step();

    // LAT=1 single fetch at 0x40
    if_req[0] = 1'b1; if_addr[0] = 32'h40;
    step();
    if_req[0] = 1'b0;
    step();
    step();

    // tie after reset: data first, fetch in the return cycle
    rst[0] = 1'b1; step(); rst[0] = 1'b0;
    if_req[0] = 1'b1; if_addr[0] = 32'h0;
    d_req[0] = 1'b1; d_we[0] = 1'b0; d_addr[0] = 32'h100;
    step();
    d_req[0] = 1'b0;
    step();
    if_req[0] = 1'b0;
    step();
    step();

    // three back-to-back writes
    d_req[0] = 1'b1; d_we[0] = 1'b1;
    for (int k = 0; k < 3; k++) begin
      d_addr[0] = 32'h10 + 32'(4 * k); d_wdata[0] = $urandom;
      step();
    end
    idle(0);
    step();

    // continuous competing reads alternate every cycle
    if_req[0] = 1'b1; d_req[0] = 1'b1; d_we[0] = 1'b0;
    for (int k = 0; k < 8; k++) begin
      if_addr[0] = 32'h1000 + 32'(k); d_addr[0] = 32'h2000 + 32'(k);
      step();
    end
    idle(0);
    step();
    step();

    // LAT=3 read at 0x20 with fetch pending behind it
    d_req[1] = 1'b1; d_we[1] = 1'b0; d_addr[1] = 32'h20;
    step();
    d_req[1] = 1'b0; if_req[1] = 1'b1; if_addr[1] = 32'h80;
    step();
    step();
    step();
    if_req[1] = 1'b0;
    for (int k = 0; k < 4; k++) step();

    // reset one cycle into a LAT=3 read, then a normal read
    d_req[1] = 1'b1; d_we[1] = 1'b0; d_addr[1] = 32'h24;
    step();
    d_req[1] = 1'b0; rst[1] = 1'b1;
    step();
    rst[1] = 1'b0;
    for (int k = 0; k < 4; k++) step();
    d_req[1] = 1'b1; d_addr[1] = 32'h28;
    step();
    d_req[1] = 1'b0;
    for (int k = 0; k < 4; k++) step();

    // randomized traffic on both instances
    for (int k = 0; k < 400; k++) begin
      drive_rand(0);
      drive_rand(1);
      step();
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
